// File: rtl/gpr_wb_if.sv
// Writeback bus between the execute/memory stages, the scheduler and the register file.
// Valid/ready: a transfer happens on a rising edge where valid && ready; ready is combinational
// from the valids and the scheduler state, never high without its valid, and a requester holds
// dest/data stable while valid is high and ready is low.
interface gpr_wb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_W-1:0]        alu_dest;
  logic [DATA_W-1:0]        alu_data;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_dest;
  logic [DATA_W-1:0]        mem_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_dest;
  logic [(1<<ADDR_W)-1:0]   busy;
  logic                     write_en;
  logic [ADDR_W-1:0]        write_dest;
  logic [DATA_W-1:0]        write_data;
  logic                     sched_state;

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, issue_en, issue_dest,
    input  alu_ready, mem_ready, busy, write_en, write_dest, write_data, sched_state
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, issue_en, issue_dest,
    output alu_ready, mem_ready, busy, write_en, write_dest, write_data, sched_state
  );
endinterface

// File: rtl/gpr_wb_sched.sv
// Single-write-port writeback arbiter (ALU vs. load) with anti-starvation for the ALU
// and a per-register outstanding-load scoreboard.
module gpr_wb_sched #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int MAX_WAIT = 4
) (
  input logic     clk,
  input logic     rst,
  gpr_wb_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic {PRIO_MEM, FORCE_ALU} state_t;

  state_t            state, state_next;
  logic [3:0]        wait_cnt, wait_next;
  logic              alu_win, alu_xfer, mem_xfer;
  logic [NREG-1:0]   busy_q, busy_next;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_dest_q;
  logic [DATA_W-1:0] wr_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PRIO_MEM;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    alu_win    = 1'b0;
    state_next = state;
    wait_next  = '0;
    if (!rst) begin
      if (state == FORCE_ALU) alu_win = bus.alu_valid;
      else                    alu_win = bus.alu_valid && !bus.mem_valid;
    end
    alu_xfer = alu_win;
    mem_xfer = !rst && bus.mem_valid && !alu_win;

    // Count consecutive refused ALU cycles, saturating at the threshold.
    if (bus.alu_valid && !alu_xfer)
      wait_next = (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1;

    case (state)
      PRIO_MEM:  if (wait_next == MAX_W) state_next = FORCE_ALU;
      FORCE_ALU: if (alu_xfer || !bus.alu_valid) state_next = PRIO_MEM;
      default:   state_next = PRIO_MEM;
    endcase
  end

  // A newer issue to the same register wins over the clearing load writeback.
  always_comb begin
    busy_next = busy_q;
    if (mem_xfer) busy_next[bus.mem_dest] = 1'b0;
    if (bus.issue_en && bus.issue_dest != '0) busy_next[bus.issue_dest] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q  <= busy_next;
      wr_en_q <= 1'b0;
      if (alu_xfer && bus.alu_dest != '0) begin
        wr_en_q   <= 1'b1;
        wr_dest_q <= bus.alu_dest;
        wr_data_q <= bus.alu_data;
      end else if (mem_xfer && bus.mem_dest != '0) begin
        wr_en_q   <= 1'b1;
        wr_dest_q <= bus.mem_dest;
        wr_data_q <= bus.mem_data;
      end
    end
  end

  assign bus.alu_ready   = alu_xfer;
  assign bus.mem_ready   = mem_xfer;
  assign bus.busy        = busy_q;
  assign bus.write_en    = wr_en_q;
  assign bus.write_dest  = wr_dest_q;
  assign bus.write_data  = wr_data_q;
  assign bus.sched_state = (state == FORCE_ALU);
endmodule

// File: tb/tb_gpr_wb_sched.sv
// Randomized and directed bench for gpr_wb_sched: reference model predicts grants, busy and
// the writeback stream; a negedge monitor pops expected register-file writes.
module tb_gpr_wb_sched;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int MAX_WAIT = 4;
  localparam int W        = ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpr_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  gpr_wb_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  // Reference model state: predicted busy vector and consecutive ALU refusals.
  logic [7:0] m_busy = '0;
  int         m_refused = 0;
  bit         last_alu_acc, last_mem_acc;
  logic       dut_ar;
  logic [5:0] g_seq;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    bit alu_win, exp_ar, exp_mr;
    logic [7:0] nb;
    #3;
    check("busy", 32'(bus.busy), 32'(m_busy));
    if (rst) begin
      exp_ar = 1'b0;
      exp_mr = 1'b0;
    end else begin
      alu_win = bus.alu_valid && (!bus.mem_valid || m_refused >= MAX_WAIT);
      exp_ar  = alu_win;
      exp_mr  = bus.mem_valid && !alu_win;
    end
    check("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
    check("mem_ready", 32'(bus.mem_ready), 32'(exp_mr));
    dut_ar = bus.alu_ready;
    if (rst) begin
      m_busy    = '0;
      m_refused = 0;
    end else begin
      if (exp_ar && bus.alu_dest != 0) exp_q.push_back({bus.alu_dest, bus.alu_data});
      if (exp_mr && bus.mem_dest != 0) exp_q.push_back({bus.mem_dest, bus.mem_data});
      if (bus.alu_valid && !exp_ar) m_refused = (m_refused + 1 > MAX_WAIT) ? MAX_WAIT : m_refused + 1;
      else                          m_refused = 0;
      nb = m_busy;
      if (exp_mr) nb[bus.mem_dest] = 1'b0;
      if (bus.issue_en && bus.issue_dest != 0) nb[bus.issue_dest] = 1'b1;
      m_busy = nb;
    end
    last_alu_acc = exp_ar;
    last_mem_acc = exp_mr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.issue_en  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_on && bus.write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got dest %0d data 0x%0h expected no write at %0t",
                 bus.write_dest, bus.write_data, $time);
      end else begin
        check("write", 32'({bus.write_dest, bus.write_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.alu_dest = '0; bus.alu_data = '0; bus.mem_dest = '0; bus.mem_data = '0;
    bus.issue_dest = '0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Reset then idle
    step();
    check("wr_en_in_rst", 32'(bus.write_en), 32'd0);
    rst = 1'b0;
    step();
    step();
    check("wr_en_idle", 32'(bus.write_en), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'h00);

    // ALU-only write
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd3; bus.alu_data = 16'hBEEF;
    step();
    idle_inputs();
    check("alu_wr_en", 32'(bus.write_en), 32'd1);
    check("alu_wr_dest", 32'(bus.write_dest), 32'd3);
    check("alu_wr_data", 32'(bus.write_data), 32'hBEEF);
    step();
    check("alu_wr_en_off", 32'(bus.write_en), 32'd0);

    // Conflict plus starvation: ALU granted on cycle 5 only
    bus.mem_valid = 1'b1; bus.mem_dest = 3'd2; bus.mem_data = 16'h2222;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd5; bus.alu_data = 16'h1234;
    g_seq = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      g_seq = {g_seq[4:0], dut_ar};
      if (last_alu_acc) bus.alu_valid = 1'b0;
    end
    check("starve_grants", 32'(g_seq), 32'b000010);
    idle_inputs();
    step();

    // Scoreboard set / clear / set-wins
    bus.issue_en = 1'b1; bus.issue_dest = 3'd6;
    step();
    idle_inputs();
    check("busy_set6", 32'(bus.busy), 32'h40);
    bus.mem_valid = 1'b1; bus.mem_dest = 3'd6; bus.mem_data = 16'h0606;
    step();
    idle_inputs();
    check("busy_clr6", 32'(bus.busy), 32'h00);
    bus.issue_en = 1'b1; bus.issue_dest = 3'd6;
    step();
    bus.mem_valid = 1'b1; bus.mem_dest = 3'd6; bus.mem_data = 16'h0666;
    step();
    idle_inputs();
    check("busy_setwins", 32'(bus.busy), 32'h40);
    bus.mem_valid = 1'b1; bus.mem_data = 16'h0667;
    step();
    idle_inputs();

    // Destination 0
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd0; bus.alu_data = 16'hFFFF;
    step();
    idle_inputs();
    check("dest0_no_write", 32'(bus.write_en), 32'd0);
    bus.issue_en = 1'b1; bus.issue_dest = 3'd0;
    step();
    idle_inputs();
    check("dest0_busy", 32'(bus.busy), 32'h00);

    // Reset mid-operation
    bus.issue_en = 1'b1; bus.issue_dest = 3'd2;
    step();
    bus.issue_dest = 3'd3;
    step();
    idle_inputs();
    check("busy_0c", 32'(bus.busy), 32'h0C);
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd1; bus.alu_data = 16'hA5A5;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_wr_en", 32'(bus.write_en), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'h00);

    // Randomized traffic across several load mixes
    for (int ph = 0; ph < 4; ph++) begin
      int pa, pm;
      pa = (ph == 0) ? 30 : (ph == 2) ? 90 : (ph == 1) ? 90 : 60;
      pm = (ph == 0) ? 90 : (ph == 2) ? 30 : (ph == 1) ? 90 : 60;
      for (int c = 0; c < 500; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        if (!bus.alu_valid || last_alu_acc) begin
          bus.alu_valid = ($urandom_range(0, 99) < pa);
          bus.alu_dest  = ADDR_W'($urandom_range(0, 7));
          bus.alu_data  = DATA_W'($urandom);
        end
        if (!bus.mem_valid || last_mem_acc) begin
          bus.mem_valid = ($urandom_range(0, 99) < pm);
          bus.mem_dest  = ADDR_W'($urandom_range(0, 7));
          bus.mem_data  = DATA_W'($urandom);
        end
        bus.issue_en   = ($urandom_range(0, 99) < 30);
        bus.issue_dest = ADDR_W'($urandom_range(0, 7));
        step();
      end
    end

    rst = 1'b0;
    idle_inputs();
    step();
    step();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gpr_wb_sched.md
Name: gpr_wb_sched

Overview:
- Writeback scheduler for the 8x16 general purpose register file, which has a single write port.
- Arbitrates between two writeback requesters: the ALU result path and the memory load path. Drives the register file's write_en/write_dest/write_data.
- Keeps a load scoreboard (busy bit per register) so the issue stage can stall on outstanding loads.
- Sits between execute/memory stages and the register file.

Parameters:
- DATA_W, 16, writeback data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- MAX_WAIT, 4, consecutive ALU-blocked cycles before ALU is forced the grant (1..15)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle
- alu_dest  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  load writeback request
- mem_ready  output  1  load request accepted this cycle
- mem_dest  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- issue_en  input  1  a load is issued this cycle
- issue_dest  input  ADDR_W  destination of the issued load
- busy  output  2**ADDR_W  scoreboard; bit i=1 means a load to register i is outstanding
- write_en  output  1  to register file write enable
- write_dest  output  ADDR_W  to register file write address
- write_data  output  DATA_W  to register file write data

Behaviour:
- Reset (rst=1 at rising edge): write_en=0, write_dest=0, write_data=0, busy=0, wait counter=0, state=PRIO_MEM. alu_ready=mem_ready=0 while rst=1.
- Handshake: a transfer occurs when valid&&ready. Ready is combinational from the valids and the current state. At most one of alu_ready/mem_ready is high per cycle. A ready is never high without its valid.
- Requesters hold dest/data stable while valid and not ready.
- FSM, two states:
  - PRIO_MEM: mem wins if mem_valid; otherwise ALU wins if alu_valid.
  - FORCE_ALU: ALU wins if alu_valid; otherwise mem wins if mem_valid.
- Wait counter:
  - Increments each cycle alu_valid=1 and alu_ready=0, saturating at MAX_WAIT.
  - Clears on any ALU transfer or when alu_valid=0.
  - PRIO_MEM -> FORCE_ALU when the counter reaches MAX_WAIT (next cycle grants ALU).
  - FORCE_ALU -> PRIO_MEM after one ALU transfer, or if alu_valid drops.
- Write port: registered, latency 1. A transfer at rising edge N drives write_en=1, write_dest, write_data during cycle N+1.
  - No transfer at edge N: write_en=0; write_dest/write_data hold their last values.
  - The register file samples on the falling edge of cycle N+1, so written data is readable from then on.
- Destination 0: the transfer is accepted (ready asserted) but write_en stays 0. Register 0 is never written, and busy[0] is constant 0.
- Scoreboard:
  - issue_en with issue_dest!=0 sets busy[issue_dest] at the next edge.
  - A mem transfer clears busy[mem_dest] at the next edge.
  - Same register set and cleared in the same cycle: set wins (newer load outstanding).
  - Issuing a load to an already-busy register leaves busy=1 (no count).
  - ALU transfers never change busy.
- Simultaneous valid, same dest on both requesters: the normal FSM priority applies. The loser writes on a later cycle and its value is final.
- Reset mid-transfer: a pending registered write is discarded (write_en=0 next cycle). The scoreboard clears, and the requesters must re-present.
- Idle (both valid=0): no state change except the wait counter clearing.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> write_en=0, busy=0x00, both readys 0 during rst and 0 after with no valids.
- ALU-only write: alu_valid=1, dest=3, data=0xBEEF for 1 cycle -> alu_ready=1 same cycle; next cycle write_en=1, write_dest=3, write_data=0xBEEF; the following cycle write_en=0.
- Conflict plus starvation, MAX_WAIT=4: mem_valid=1 continuously (dest=2), alu_valid=1 (dest=5, 0x1234) -> mem granted 4 cycles, ALU granted on cycle 5, mem resumes on cycle 6; write_dest sequence is 2,2,2,2,5,2.
- Scoreboard: issue_en dest=6 -> busy=0x40 next cycle; mem transfer dest=6 -> busy=0x00 next cycle. Issue dest=6 in the same cycle as a mem transfer to 6 -> busy[6] stays 1.
- Dest 0: alu_valid dest=0 data=0xFFFF -> alu_ready=1, write_en stays 0. issue_en dest=0 -> busy stays 0x00.
- Reset mid-operation: ALU transfer at edge N with rst=1 at edge N+1, busy=0x0C beforehand -> write_en=0, busy=0x00 after reset.
